// File: rtl/regfile_op_ctrl.sv
// Read/execute/write-back sequencer that is the only master on the 8x16 dual-read register file.
// Build option: define RFCTRL_SWAP_EN to build the two-write SWAP path; without it, opcode 111 is a NOP.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start, command fields latched on accept
// READ   | read addresses presented, operands captured at end of cycle
// EXEC   | ALU result and flags registered
// WRITE  | write-back of result to rd
// WRITE2 | SWAP only: old rd value written to rs
// DONE   | completion pulse, then back to IDLE
module regfile_op_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  opcode,
    input  logic [2:0]  rd,
    input  logic [2:0]  rs,
    input  logic [2:0]  rt,
    input  logic [15:0] imm,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        zero,
    output logic        carry,
    output logic        WriteEn,
    output logic [2:0]  WriteReg,
    output logic [15:0] WriteData,
    output logic [2:0]  ReadRegEven,
    output logic [2:0]  ReadRegOdd,
    input  logic [15:0] ReadDataEven,
    input  logic [15:0] ReadDataOdd
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_LDI  = 3'b110;
    localparam logic [2:0] OP_SWAP = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd5
`ifdef RFCTRL_SWAP_EN
        , S_WRITE2 = 3'd4
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, rd_q;
    logic [15:0] imm_q, opa_q, opb_q, res_q;
    logic [16:0] sum, diff;
    logic [15:0] alu_res;
    logic        alu_carry;
    logic        swap_in, swap_q, op_writes, op_flags;

    logic        busy_d, done_d, zero_d, carry_d, we_d;
    logic [15:0] result_d, wdata_d;
    logic [2:0]  wreg_d, rre_d, rro_d;

`ifdef RFCTRL_SWAP_EN
    logic [2:0] rs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rs_q <= 3'd0;
        else if (state_q == S_IDLE && start)
            rs_q <= rs;
    end

    assign swap_in   = (opcode == OP_SWAP);
    assign swap_q    = (op_q == OP_SWAP);
    assign op_writes = (op_q != OP_NOP);
`else
    assign swap_in   = 1'b0;
    assign swap_q    = 1'b0;
    assign op_writes = (op_q != OP_NOP) && (op_q != OP_SWAP);
`endif
    assign op_flags = (op_q != OP_NOP) && (op_q != OP_SWAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_NOP;
            rd_q  <= 3'd0;
            imm_q <= 16'd0;
            opa_q <= 16'd0;
            opb_q <= 16'd0;
            res_q <= 16'd0;
        end else begin
            if (state_q == S_IDLE && start) begin
                op_q  <= opcode;
                rd_q  <= rd;
                imm_q <= imm;
            end
            if (state_q == S_READ) begin
                opa_q <= ReadDataEven;
                opb_q <= ReadDataOdd;
            end
            if (state_q == S_EXEC)
                res_q <= alu_res;
        end
    end

    // 17-bit forms give carry-out for ADD and borrow for SUB in bit 16.
    assign sum  = {1'b0, opa_q} + {1'b0, opb_q};
    assign diff = {1'b0, opa_q} - {1'b0, opb_q};

    always_comb begin
        alu_res   = opa_q;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res   = sum[15:0];
                alu_carry = sum[16];
            end
            OP_SUB: begin
                alu_res   = diff[15:0];
                alu_carry = diff[16];
            end
            OP_AND:  alu_res = opa_q & opb_q;
            OP_OR:   alu_res = opa_q | opb_q;
            OP_LDI:  alu_res = imm_q;
            default: alu_res = opa_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state plus next value of every registered output.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy;
        done_d   = 1'b0;
        we_d     = 1'b0;
        wreg_d   = WriteReg;
        wdata_d  = WriteData;
        result_d = result;
        zero_d   = zero;
        carry_d  = carry;
        rre_d    = ReadRegEven;
        rro_d    = ReadRegOdd;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    busy_d  = 1'b1;
                    rre_d   = rs;
                    rro_d   = swap_in ? rd : rt;
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                if (op_flags) begin
                    zero_d  = (alu_res == 16'd0);
                    carry_d = alu_carry;
                end
                if (op_writes) begin
                    state_d = S_WRITE;
                    we_d    = 1'b1;
                    wreg_d  = rd_q;
                    wdata_d = alu_res;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_WRITE: begin
                result_d = res_q;
`ifdef RFCTRL_SWAP_EN
                if (swap_q) begin
                    state_d = S_WRITE2;
                    we_d    = 1'b1;
                    wreg_d  = rs_q;
                    wdata_d = opb_q;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
`else
                state_d = S_DONE;
                done_d  = 1'b1;
`endif
            end
`ifdef RFCTRL_SWAP_EN
            S_WRITE2: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            WriteEn     <= 1'b0;
            WriteReg    <= 3'd0;
            WriteData   <= 16'd0;
            result      <= 16'd0;
            zero        <= 1'b0;
            carry       <= 1'b0;
            ReadRegEven <= 3'd0;
            ReadRegOdd  <= 3'd0;
        end else begin
            busy        <= busy_d;
            done        <= done_d;
            WriteEn     <= we_d;
            WriteReg    <= wreg_d;
            WriteData   <= wdata_d;
            result      <= result_d;
            zero        <= zero_d;
            carry       <= carry_d;
            ReadRegEven <= rre_d;
            ReadRegOdd  <= rro_d;
        end
    end

    logic unused_swap;
    assign unused_swap = swap_q;

endmodule

// File: tb/tb_regfile_op_ctrl.sv
// Bench for regfile_op_ctrl: behavioural register file plus a command-level reference model.
// Honours RFCTRL_SWAP_EN the same way the design does.
module tb_regfile_op_ctrl;

`ifdef RFCTRL_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif

    localparam logic [2:0] NOP = 3'd0, MOV = 3'd1, ADD = 3'd2, SUB = 3'd3,
                           AND_ = 3'd4, OR_ = 3'd5, LDI = 3'd6, SWP = 3'd7;

    logic        clk, rst_n, start;
    logic [2:0]  opcode, rd, rs, rt;
    logic [15:0] imm;
    logic        busy, done, zero, carry, WriteEn;
    logic [15:0] result, WriteData, ReadDataEven, ReadDataOdd;
    logic [2:0]  WriteReg, ReadRegEven, ReadRegOdd;

    regfile_op_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .rd(rd), .rs(rs), .rt(rt), .imm(imm),
        .busy(busy), .done(done), .result(result), .zero(zero), .carry(carry),
        .WriteEn(WriteEn), .WriteReg(WriteReg), .WriteData(WriteData),
        .ReadRegEven(ReadRegEven), .ReadRegOdd(ReadRegOdd),
        .ReadDataEven(ReadDataEven), .ReadDataOdd(ReadDataOdd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] rf [8] = '{default: 16'h0000};
    assign ReadDataEven = rf[ReadRegEven];
    assign ReadDataOdd  = rf[ReadRegOdd];

    int wr_cnt = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        if (WriteEn) begin
            rf[WriteReg] <= WriteData;
            wr_cnt <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    // Reference model state: architectural registers and status.
    logic [15:0] mreg [8] = '{default: 16'h0000};
    logic [15:0] mresult = 16'h0;
    logic        mzero = 1'b0, mcarry = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Command semantics at architectural level; lat = cycles from accept to done.
    task automatic model_apply(input logic [2:0] op, input logic [2:0] rdv, rsv, rtv,
                               input logic [15:0] immv, output int lat, output int nwr);
        logic [15:0] a, b, r;
        logic [16:0] wide;
        logic        c;
        a = mreg[rsv];
        b = mreg[rtv];
        r = 16'h0;
        c = 1'b0;
        lat = 4;
        nwr = 1;
        case (op)
            MOV:  r = a;
            ADD:  begin wide = 17'(a) + 17'(b); r = wide[15:0]; c = wide[16]; end
            SUB:  begin r = a - b; c = (a < b); end
            AND_: r = a & b;
            OR_:  r = a | b;
            LDI:  r = immv;
            default: ;
        endcase
        if (op == NOP || (op == SWP && !SWAP_EN)) begin
            lat = 3;
            nwr = 0;
        end else if (op == SWP) begin
            b = mreg[rdv];
            mreg[rdv] = a;
            mreg[rsv] = b;
            mresult = a;
            lat = 5;
            nwr = 2;
        end else begin
            mreg[rdv] = r;
            mresult = r;
            mzero = (r == 16'h0);
            mcarry = c;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, " result"}, 32'(result), 32'(mresult));
        chk({tag, " zero"}, 32'(zero), 32'(mzero));
        chk({tag, " carry"}, 32'(carry), 32'(mcarry));
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s r%0d", tag, i), 32'(rf[i]), 32'(mreg[i]));
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [2:0] rdv, rsv, rtv,
                           input logic [15:0] immv, input string tag);
        int lat, nwr, n, w0, d0;
        model_apply(op, rdv, rsv, rtv, immv, lat, nwr);
        w0 = wr_cnt;
        d0 = done_cnt;
        opcode = op; rd = rdv; rs = rsv; rt = rtv; imm = immv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " busy after accept"}, 32'(busy), 32'd1);
        n = 1;
        while (done !== 1'b1 && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " done latency"}, 32'(n), 32'(lat));
        @(posedge clk); #1;
        chk({tag, " done one cycle"}, 32'(done), 32'd0);
        chk({tag, " busy cleared"}, 32'(busy), 32'd0);
        chk({tag, " write count"}, 32'(wr_cnt - w0), 32'(nwr));
        chk({tag, " done count"}, 32'(done_cnt - d0), 32'd1);
        check_state(tag);
    endtask

    initial begin
        int n, w0, d0, lat1, nw1, lat2, nw2;
        rst_n = 1'b0; start = 1'b0;
        opcode = 3'd0; rd = 3'd0; rs = 3'd0; rt = 3'd0; imm = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset WriteEn", 32'(WriteEn), 32'd0);
        chk("reset outputs", {result, WriteData}, 32'h0);
        chk("reset addrs", {23'd0, WriteReg, ReadRegEven, ReadRegOdd}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Abort an LDI in EXEC: outputs clear at once, no write, no done.
        w0 = wr_cnt;
        d0 = done_cnt;
        opcode = LDI; rd = 3'd3; rs = 3'd0; rt = 3'd0; imm = 16'h1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("abort read addr", 32'(ReadRegEven), 32'd0);
        @(posedge clk); #1;
        chk("abort busy before reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort flags", {30'd0, zero, carry}, 32'd0);
        chk("abort WriteEn", 32'(WriteEn), 32'd0);
        chk("abort outputs", {result, WriteData}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort no write", 32'(wr_cnt - w0), 32'd0);
        chk("abort no done", 32'(done_cnt - d0), 32'd0);
        chk("abort r3", 32'(rf[3]), 32'h0);

        run_cmd(LDI, 3'd3, 3'd0, 3'd0, 16'h1234, "ldi r3");
        run_cmd(LDI, 3'd1, 3'd0, 3'd0, 16'hFFFF, "ldi r1");
        run_cmd(LDI, 3'd2, 3'd0, 3'd0, 16'h0001, "ldi r2");
        run_cmd(ADD, 3'd4, 3'd1, 3'd2, 16'h0, "add carry");
        chk("add carry r4", 32'(rf[4]), 32'h0000);
        chk("add carry flags", {30'd0, zero, carry}, 32'd3);
        run_cmd(LDI, 3'd1, 3'd0, 3'd0, 16'h0005, "ldi r1b");
        run_cmd(LDI, 3'd2, 3'd0, 3'd0, 16'h0007, "ldi r2b");
        run_cmd(SUB, 3'd5, 3'd1, 3'd2, 16'h0, "sub borrow");
        chk("sub borrow r5", 32'(rf[5]), 32'hFFFE);
        chk("sub borrow flags", {30'd0, zero, carry}, 32'd1);

        // Back-to-back with start held high; fields change while busy and must be ignored.
        model_apply(ADD, 3'd6, 3'd1, 3'd2, 16'h0, lat1, nw1);
        model_apply(MOV, 3'd7, 3'd6, 3'd0, 16'h0, lat2, nw2);
        w0 = wr_cnt;
        d0 = done_cnt;
        opcode = ADD; rd = 3'd6; rs = 3'd1; rt = 3'd2; start = 1'b1;
        @(posedge clk); #1;
        opcode = MOV; rd = 3'd7; rs = 3'd6; rt = 3'd0;
        n = 1;
        while (done !== 1'b1 && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b first latency", 32'(n), 32'(lat1));
        @(posedge clk); #1;
        chk("b2b idle gap busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b second accept", 32'(busy), 32'd1);
        n = 1;
        while (done !== 1'b1 && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b second latency", 32'(n), 32'(lat2));
        @(posedge clk); #1;
        chk("b2b writes", 32'(wr_cnt - w0), 32'(nw1 + nw2));
        chk("b2b dones", 32'(done_cnt - d0), 32'd2);
        chk("b2b r7", 32'(rf[7]), 32'hFFFE + 32'h0 - 32'hFFFE + 32'(mreg[6]));
        check_state("b2b");

        run_cmd(LDI, 3'd0, 3'd0, 3'd0, 16'hAAAA, "ldi r0");
        run_cmd(LDI, 3'd7, 3'd0, 3'd0, 16'h5555, "ldi r7");
        run_cmd(SWP, 3'd0, 3'd7, 3'd3, 16'h0, "swap");
        if (SWAP_EN) chk("swap r0", 32'(rf[0]), 32'h5555);
        else         chk("swap r0", 32'(rf[0]), 32'hAAAA);
        run_cmd(NOP, 3'd2, 3'd1, 3'd4, 16'hBEEF, "nop");

        for (int k = 0; k < 40; k++) begin
            run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                    $sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
